timebase_gen: RTL and testbench
===============================

Name: timebase_gen

Overview:
Parametrised timebase generator. It produces a one-cycle period pulse from a runtime-programmable divider, an N-digit display scan select with a one-hot strobe, and a one-cycle tick on the rising edge of a selectable counter bit. Sits at the top of the counter/display datapath and drives the display mux, the debounce filters and the seconds counter.

Parameters:
CNT_WIDTH, 32, width of the main divider counter and period register
DEF_PERIOD, 25_000_000, period in clk cycles loaded at reset (must be >=1)
DIGITS, 4, number of display digits scanned (>=2)
SEL_W, 2, width of dig_sel (must be >= clog2(DIGITS))
SCAN_DIV, 32768, clk cycles per digit slot (>=1)
TICK_TAP, 22, main-counter bit whose rising edge generates tick (< CNT_WIDTH)

Ports:
clk, input, 1, clock
rst_n, input, 1, asynchronous active-low reset
en, input, 1, main counter advance enable
clr, input, 1, synchronous clear of main counter (priority over en)
period_wr, input, 1, period write strobe
period_in, input, CNT_WIDTH, new period in cycles (0 ignored)
pulse_out, output, 1, one-cycle pulse per period
dig_sel, output, SEL_W, current digit index
dig_strb, output, DIGITS, one-hot digit strobe (bit i = digit i)
tick, output, 1, one-cycle pulse on rising edge of cnt[TICK_TAP]

Behaviour:
- Reset (rst_n=0, async): cnt=0, period_q=DEF_PERIOD, pending=0, pulse_out=0, scan prescaler=0, dig_sel=0, dig_strb=1, tick=0, tap history=0.
- Period update: period_wr=1 with period_in!=0 latches period_in into a shadow register and sets pending. period_in==0 is ignored and leaves the shadow register untouched. A second write while pending overwrites the first; last write wins.
- Pending applies to period_q only at a wrap or on clr, then pending clears. period_q never changes mid-period.
- Main counter, priority clr > en:
  - clr=1: cnt<=0, no pulse.
  - en=0: cnt holds.
  - en=1 and cnt==period_q-1 (terminal): cnt<=0. This is a wrap.
  - otherwise: cnt<=cnt+1.
- pulse_out is registered, 1 cycle wide, high in the cycle after a wrap. It therefore rises on the same edge on which cnt becomes 0.
- Period 1: pulse_out is high on every enabled cycle.
- Simultaneous period_wr and wrap: the new value goes to the shadow register only and applies at the next wrap.
- Scan path ignores en and clr:
  - The prescaler runs 0..SCAN_DIV-1 and wraps.
  - On prescaler terminal, dig_sel advances, wrapping from DIGITS-1 to 0. This holds for non-power-of-two DIGITS; unused codes are never reached.
  - dig_strb is decoded combinationally from the dig_sel register, always exactly one-hot.
- Tick:
  - A register holds the previous cnt[TICK_TAP].
  - tick is registered: high for 1 cycle, in the cycle after cnt[TICK_TAP] goes 0->1.
  - No tick on a 1->0 transition, on clr, or while the counter is held.
  - If period_q <= 2^TICK_TAP, the bit never rises and tick never fires.
- Reset mid-operation returns every state to its reset value immediately. A pending period write is discarded.

Test Plan:
Use DEF_PERIOD=10, DIGITS=3, SEL_W=2, SCAN_DIV=4, TICK_TAP=2, and en=1 unless noted.
1. Release reset -> pulse_out is high for exactly 1 cycle after the 10th edge, then after the 20th, 30th, and so on. cnt sequence is 0..9,0.
2. Write period_in=5 when cnt=3 -> next pulse still after edge 10, then every 5 cycles. Writing period_in=0 instead -> period stays 10.
3. Drop en for 7 cycles at cnt=4 -> cnt holds 4 and the pulse is delayed to edge 17. dig_sel keeps advancing. No extra tick.
4. Write period_in=6, then assert clr at cnt=7 -> cnt=0 next cycle with no pulse. Pulses then follow every 6 cycles. Asserting clr and en together -> clear wins.
5. Scan -> dig_sel goes 0,1,2,0, each value held 4 cycles. dig_strb goes 001,010,100,001. Never 3; never zero or multi-hot.
6. Tick with period 10 -> one 1-cycle tick per period, the cycle after cnt becomes 4. Period 3 -> no tick. Assert rst_n mid-period -> all outputs 0, dig_strb=001, period back to 10.

Source files
------------

// File: rtl/timebase_gen.sv
// timebase_gen
//   Timebase for the counter/display datapath. Produces three timing outputs:
//   - a one-cycle period pulse from a runtime-programmable main divider,
//   - a digit scan select with a one-hot strobe for the display mux,
//   - a one-cycle tick on each rising edge of one chosen main-counter bit.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   en         in   main counter advance enable
//   clr        in   synchronous clear of main counter (wins over en)
//   period_wr  in   period write strobe
//   period_in  in   new period in cycles; a value of zero is ignored
//   pulse_out  out  one-cycle pulse, high in the cycle after the counter wraps
//   dig_sel    out  current digit index, 0..DIGITS-1
//   dig_strb   out  one-hot digit strobe (bit i = digit i)
//   tick       out  one-cycle pulse after cnt[TICK_TAP] rises
module timebase_gen #(
    parameter int CNT_WIDTH  = 32,
    parameter int DEF_PERIOD = 25_000_000,
    parameter int DIGITS     = 4,
    parameter int SEL_W      = 2,
    parameter int SCAN_DIV   = 32768,
    parameter int TICK_TAP   = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 period_wr,
    input  logic [CNT_WIDTH-1:0] period_in,
    output logic                 pulse_out,
    output logic [SEL_W-1:0]     dig_sel,
    output logic [DIGITS-1:0]    dig_strb,
    output logic                 tick
);

    localparam int                   PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_WIDTH-1:0] DEF_P    = CNT_WIDTH'(DEF_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0]     PRE_ONE  = PRE_W'(1);
    localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(DIGITS - 1);
    localparam logic [SEL_W-1:0]     SEL_ONE  = SEL_W'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 pulse_q, pulse_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 tap_q, tap_d;
    logic                 tick_q, tick_d;

    logic terminal;
    logic wrap;

    assign terminal = (cnt_q == (period_q - CNT_ONE));
    assign wrap     = en & ~clr & terminal;

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pre_d     = pre_q + PRE_ONE;
        sel_d     = sel_q;
        pulse_d   = wrap;
        tap_d     = cnt_q[TICK_TAP];
        tick_d    = cnt_q[TICK_TAP] & ~tap_q;

        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = terminal ? '0 : cnt_q + CNT_ONE;
        end

        // A pending period only takes effect at a period boundary (wrap or clear),
        // so the running period is never cut short or stretched.
        if ((wrap || clr) && pending_q) begin
            period_d  = shadow_q;
            pending_d = 1'b0;
        end

        // Evaluated after the apply step: a write that coincides with a wrap
        // stays in the shadow register for the following period.
        if (period_wr && (period_in != '0)) begin
            shadow_d  = period_in;
            pending_d = 1'b1;
        end

        // Scan path runs free of en/clr.
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            period_q  <= DEF_P;
            shadow_q  <= DEF_P;
            pending_q <= 1'b0;
            pulse_q   <= 1'b0;
            pre_q     <= '0;
            sel_q     <= '0;
            tap_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            pre_q     <= pre_d;
            sel_q     <= sel_d;
            tap_q     <= tap_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        dig_strb = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_strb[i] = (sel_q == SEL_W'(i));
        end
    end

    assign pulse_out = pulse_q;
    assign dig_sel   = sel_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_timebase_gen.sv
module tb_timebase_gen;

    localparam int CW   = 8;
    localparam int DEFP = 10;
    localparam int DIG  = 3;
    localparam int SW   = 2;
    localparam int SDIV = 4;
    localparam int TAP  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic          period_wr;
    logic [CW-1:0] period_in;
    logic          pulse_out;
    logic [SW-1:0] dig_sel;
    logic [DIG-1:0] dig_strb;
    logic          tick;

    int checks   = 0;
    int failures = 0;

    timebase_gen #(
        .CNT_WIDTH (CW),
        .DEF_PERIOD(DEFP),
        .DIGITS    (DIG),
        .SEL_W     (SW),
        .SCAN_DIV  (SDIV),
        .TICK_TAP  (TAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .period_wr(period_wr),
        .period_in(period_in),
        .pulse_out(pulse_out),
        .dig_sel  (dig_sel),
        .dig_strb (dig_strb),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: integer counter and period, scan position derived from
    // the number of edges since reset, tick from a history of counter values.
    int  m_cnt;
    int  m_period;
    int  m_shadow;
    bit  m_pend;
    int  m_edges;
    int  cnt_hist[$];
    bit  exp_pulse;
    bit  exp_tick;
    bit  m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     = 0;
            m_period  = DEFP;
            m_shadow  = DEFP;
            m_pend    = 0;
            m_edges   = 0;
            cnt_hist  = {0, 0};
            exp_pulse = 0;
            exp_tick  = 0;
        end else begin
            m_edges++;
            m_wrap    = en && !clr && (m_cnt == m_period - 1);
            exp_pulse = m_wrap;
            exp_tick  = (((cnt_hist[1] >> TAP) & 1) == 1) && (((cnt_hist[0] >> TAP) & 1) == 0);
            if ((m_wrap || clr) && m_pend) begin
                m_period = m_shadow;
                m_pend   = 0;
            end
            if (period_wr && period_in != 0) begin
                m_shadow = int'(period_in);
                m_pend   = 1;
            end
            if (clr) m_cnt = 0;
            else if (en) m_cnt = m_wrap ? 0 : m_cnt + 1;
            void'(cnt_hist.pop_front());
            cnt_hist.push_back(m_cnt);
        end
    end

    always @(negedge clk) begin
        int es;
        es = (m_edges / SDIV) % DIG;
        chk("pulse_out", int'(pulse_out), int'(exp_pulse));
        chk("tick", int'(tick), int'(exp_tick));
        chk("dig_sel", int'(dig_sel), es);
        chk("dig_strb", int'(dig_strb), 1 << es);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; period_wr = 1'b0; period_in = '0;
        #1;
        chk("rst_pulse", int'(pulse_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_sel", int'(dig_sel), 0);
        chk("rst_strb", int'(dig_strb), 1);
        step(2);
        rst_n = 1'b1;                               // edge count e=0

        step(4);                                    // e4
        chk("lit_sel_e4", int'(dig_sel), 1);
        chk("lit_strb_e4", int'(dig_strb), 2);
        chk("lit_tick_e4", int'(tick), 0);
        step(1);                                    // e5
        chk("lit_tick_e5", int'(tick), 1);
        step(3);                                    // e8
        chk("lit_strb_e8", int'(dig_strb), 4);
        step(1);                                    // e9
        chk("lit_pulse_e9", int'(pulse_out), 0);
        step(1);                                    // e10
        chk("lit_pulse_e10", int'(pulse_out), 1);
        step(1);                                    // e11
        chk("lit_pulse_e11", int'(pulse_out), 0);
        chk("lit_sel_e11", int'(dig_sel), 2);
        step(9);                                    // e20
        chk("lit_pulse_e20", int'(pulse_out), 1);

        step(3);                                    // e23, cnt=3: write period 5
        period_wr = 1'b1; period_in = 8'd5;
        step(1);
        period_wr = 1'b0;
        step(6);                                    // e30
        chk("lit_pulse_old_period", int'(pulse_out), 1);
        step(4);                                    // e34
        chk("lit_pulse_e34", int'(pulse_out), 0);
        step(1);                                    // e35
        chk("lit_pulse_new_period", int'(pulse_out), 1);
        step(5);                                    // e40: zero write is ignored
        chk("lit_pulse_e40", int'(pulse_out), 1);
        period_wr = 1'b1; period_in = 8'd0;
        step(1);
        period_wr = 1'b0;
        step(4);                                    // e45
        chk("lit_pulse_zero_wr", int'(pulse_out), 1);

        step(4);                                    // e49, cnt=4: hold for 7 edges
        en = 1'b0;
        step(1);                                    // e50
        chk("lit_tick_hold", int'(tick), 1);
        step(5);                                    // e55
        chk("lit_pulse_hold", int'(pulse_out), 0);
        step(1);                                    // e56
        en = 1'b1;
        step(1);                                    // e57
        chk("lit_pulse_delayed", int'(pulse_out), 1);

        period_wr = 1'b1; period_in = 8'd6;         // pending 6
        step(1);
        period_wr = 1'b0;
        step(2);                                    // e60, cnt=3: clr with en
        clr = 1'b1;
        step(1);                                    // e61
        clr = 1'b0;
        chk("lit_pulse_clr", int'(pulse_out), 0);
        step(5);                                    // e66
        chk("lit_pulse_e66", int'(pulse_out), 0);
        step(1);                                    // e67
        chk("lit_pulse_p6", int'(pulse_out), 1);
        step(5);                                    // e72: write coincides with wrap
        period_wr = 1'b1; period_in = 8'd3;
        step(1);                                    // e73
        period_wr = 1'b0;
        chk("lit_pulse_e73", int'(pulse_out), 1);
        step(6);                                    // e79: still period 6
        chk("lit_pulse_e79", int'(pulse_out), 1);
        step(2);                                    // e81
        chk("lit_pulse_e81", int'(pulse_out), 0);
        step(1);                                    // e82
        chk("lit_pulse_p3", int'(pulse_out), 1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("lit_tick_p3", int'(tick), 0);
        end                                         // e85
        chk("lit_pulse_e85", int'(pulse_out), 1);

        period_wr = 1'b1; period_in = 8'd1;
        step(1);
        period_wr = 1'b0;
        step(2);                                    // e88
        chk("lit_pulse_p1_a", int'(pulse_out), 1);
        step(1);
        chk("lit_pulse_p1_b", int'(pulse_out), 1);
        step(1);                                    // e90
        chk("lit_pulse_p1_c", int'(pulse_out), 1);
        en = 1'b0;
        step(1);                                    // e91
        chk("lit_pulse_p1_held", int'(pulse_out), 0);
        en = 1'b1;
        period_wr = 1'b1; period_in = 8'd7;
        step(1);
        period_wr = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pulse", int'(pulse_out), 0);
        chk("mid_rst_tick", int'(tick), 0);
        chk("mid_rst_sel", int'(dig_sel), 0);
        chk("mid_rst_strb", int'(dig_strb), 1);
        step(1);
        rst_n = 1'b1;
        step(9);
        chk("lit_pulse_after_rst_e9", int'(pulse_out), 0);
        step(1);
        chk("lit_pulse_after_rst_e10", int'(pulse_out), 1);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
